// File: rtl/fp_add_pkg.sv
// Shared types and constants for the single-precision adder scheduler.
// Bit-field positions describe the IEEE-754 binary32 layout.
package fp_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    localparam int IEEE_W  = 32;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_MSB = 22;

    // Exponent and mantissa both zero, sign ignored.
    function automatic logic is_zero(input logic [EXP_MSB:0] value);
        return value == '0;
    endfunction

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the pointer and
// returns the first active request as a one-hot grant plus its index.
module fp_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    int               w_k;
    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            w_pos = IDX_W'(w_k);
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one ieee_adder among NUM_REQ requesters with round-robin arbitration.
// Optional FP_ADD_SCHED_ZERO_BYPASS_EN answers zero-operand requests without the adder.
module fp_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IEEE_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*IEEE_W-1:0] req_a,
    input  logic [NUM_REQ*IEEE_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic                      resp_ready,
    output logic [IEEE_W-1:0]         resp_sum,
    output logic                      busy,
    output logic                      add_enable,
    output logic [IEEE_W-1:0]         add_ieee_1,
    output logic [IEEE_W-1:0]         add_ieee_2,
    input  logic [IEEE_W-1:0]         add_ieee_sum,
    input  logic                      add_state
);

    import fp_add_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t      r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_owner;

    logic              w_canGrant;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_nextPtr;
    logic [IEEE_W-1:0] w_a;
    logic [IEEE_W-1:0] w_b;
    logic              w_aFirst;
    logic              w_bypass;
    logic [IEEE_W-1:0] w_bypassSum;

    // Grants are only offered while idle and the shared adder is free.
    assign w_canGrant = (r_state == IDLE) && !add_state && !rst;
    assign w_req      = req_valid & {NUM_REQ{w_canGrant}};
    assign req_ready  = w_grant;
    assign busy       = (r_state != IDLE);

    fp_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_arbiter (
        .i_req  (w_req),
        .i_ptr  (r_ptr),
        .o_grant(w_grant),
        .o_idx  (w_idx)
    );

    assign w_a       = req_a[w_idx*IEEE_W +: IEEE_W];
    assign w_b       = req_b[w_idx*IEEE_W +: IEEE_W];
    assign w_aFirst  = w_a[EXP_MSB:EXP_LSB] >= w_b[EXP_MSB:EXP_LSB];
    assign w_nextPtr = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

`ifdef FP_ADD_SCHED_ZERO_BYPASS_EN
    assign w_bypass    = is_zero(w_a[EXP_MSB:0]) || is_zero(w_b[EXP_MSB:0]);
    assign w_bypassSum = is_zero(w_a[EXP_MSB:0]) ? w_b : w_a;
`else
    assign w_bypass    = 1'b0;
    assign w_bypassSum = '0;
`endif

    // Operation sequencer: launch, wait for the adder to go idle, hand back the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            resp_valid <= '0;
            resp_sum   <= '0;
            add_enable <= 1'b0;
            add_ieee_1 <= '0;
            add_ieee_2 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_owner <= w_idx;
                        r_ptr   <= w_nextPtr;
                        if (w_bypass) begin
                            resp_sum   <= w_bypassSum;
                            resp_valid <= w_grant;
                            r_state    <= RESP;
                        end else begin
                            add_enable <= 1'b1;
                            add_ieee_1 <= w_aFirst ? w_a : w_b;
                            add_ieee_2 <= w_aFirst ? w_b : w_a;
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    add_enable <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (!add_state) begin
                        resp_sum   <= add_ieee_sum;
                        resp_valid <= NUM_REQ'(1) << r_owner;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
